lbp_hist: RTL and testbench

- Downstream stage of the LBP operator. Consumes the LBP result stream (lbp_valid / lbp_addr / lbp_data / finish).
- Builds a 256-bin histogram of LBP codes in an internal register array.
- After the LBP stage raises finish, streams the 256 bins out in order over a valid/ready handshake.
- Feeds the texture-descriptor / compare logic that follows.

---
 rtl/lbp_hist.sv | 170 +++++++++++++++++
 tb/tb_lbp_hist.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes.
// Sweeps all bins to zero, accumulates codes until the LBP stage raises finish,
// then streams bins 0..255 out over a valid/ready handshake and parks in DONE.
// Optional macro LBP_HIST_ADDR_CHECK_EN: drop border-pixel results and flag addr_err.
module lbp_hist #(
    parameter int unsigned COUNT_W = 14,
    parameter int unsigned PIX_W   = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lbp_valid,
    input  logic [13:0]        lbp_addr,
    input  logic [7:0]         lbp_data,
    input  logic               finish,
    output logic               hist_ready,
    output logic               hist_valid,
    input  logic               hist_rd_ready,
    output logic [7:0]         hist_bin,
    output logic [COUNT_W-1:0] hist_count,
    output logic [PIX_W-1:0]   pix_cnt,
    output logic               hist_done
`ifdef LBP_HIST_ADDR_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StAccum = 2'd1,
        StDump  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         clr_idx_q, clr_idx_d;
    logic [7:0]         dump_idx_q, dump_idx_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               hist_done_q, hist_done_d;

    // Bin storage: one write port, written by the clear sweep or the accumulate path.
    logic [COUNT_W-1:0] bins_q [256];
    logic               bin_we;
    logic [7:0]         bin_waddr;
    logic [COUNT_W-1:0] bin_wdata;

    logic               addr_ok;

`ifdef LBP_HIST_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;
    // Border pixels have no full 3x3 neighbourhood and cannot carry a valid code.
    always_comb begin
        addr_ok = (lbp_addr[6:0] != 7'd0) && (lbp_addr[6:0] != 7'd127) &&
                  (lbp_addr[13:7] != 7'd0) && (lbp_addr[13:7] != 7'd127);
    end
    assign addr_err = addr_err_q;
`else
    logic unused_addr;
    assign unused_addr = ^lbp_addr;
    assign addr_ok     = 1'b1;
`endif

    // Next-state, bin write port and counters.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        dump_idx_d  = dump_idx_q;
        pix_cnt_d   = pix_cnt_q;
        hist_done_d = hist_done_q;
        bin_we      = 1'b0;
        bin_waddr   = 8'd0;
        bin_wdata   = '0;
`ifdef LBP_HIST_ADDR_CHECK_EN
        addr_err_d  = addr_err_q;
`endif
        unique case (state_q)
            StClear: begin
                bin_we    = 1'b1;
                bin_waddr = clr_idx_q;
                bin_wdata = '0;
                clr_idx_d = clr_idx_q + 8'd1;
                if (clr_idx_q == 8'hFF) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (lbp_valid && addr_ok) begin
                    bin_waddr = lbp_data;
                    // Saturating bin: skip the write once the counter is full.
                    if (bins_q[lbp_data] != {COUNT_W{1'b1}}) begin
                        bin_we    = 1'b1;
                        bin_wdata = bins_q[lbp_data] + 1'b1;
                    end
                    if (pix_cnt_q != {PIX_W{1'b1}}) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
`ifdef LBP_HIST_ADDR_CHECK_EN
                if (lbp_valid && !addr_ok) begin
                    addr_err_d = 1'b1;
                end
`endif
                if (finish) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                if (hist_rd_ready) begin
                    dump_idx_d = dump_idx_q + 8'd1;
                    if (dump_idx_q == 8'hFF) begin
                        state_d     = StDone;
                        hist_done_d = 1'b1;
                    end
                end
            end
            StDone: begin
                hist_done_d = 1'b1;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClear;
            clr_idx_q   <= 8'd0;
            dump_idx_q  <= 8'd0;
            pix_cnt_q   <= '0;
            hist_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            dump_idx_q  <= dump_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            hist_done_q <= hist_done_d;
        end
    end

`ifdef LBP_HIST_ADDR_CHECK_EN
    // Sticky border-address error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end
`endif

    // Bin array has no reset; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (!reset && bin_we) begin
            bins_q[bin_waddr] <= bin_wdata;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        hist_ready = (state_q == StAccum);
        hist_valid = (state_q == StDump);
        hist_bin   = (state_q == StDump) ? dump_idx_q : 8'd0;
        hist_count = (state_q == StDump) ? bins_q[dump_idx_q] : '0;
        pix_cnt    = pix_cnt_q;
        hist_done  = hist_done_q;
    end

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: scoreboard bench for lbp_hist (default build, COUNT_W = PIX_W = 14).
// A reference histogram is built as codes are driven; on finish it is pushed to a
// queue and popped/compared bin by bin as the DUT dumps.
module tb_lbp_hist;

    localparam int MAXC = 16383;

    logic        clk;
    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_ready;
    logic        hist_valid;
    logic        hist_rd_ready;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic [13:0] pix_cnt;
    logic        hist_done;
`ifdef LBP_HIST_ADDR_CHECK_EN
    logic        addr_err;
`endif

    lbp_hist u_dut (
        .clk           (clk),
        .reset         (reset),
        .lbp_valid     (lbp_valid),
        .lbp_addr      (lbp_addr),
        .lbp_data      (lbp_data),
        .finish        (finish),
        .hist_ready    (hist_ready),
        .hist_valid    (hist_valid),
        .hist_rd_ready (hist_rd_ready),
        .hist_bin      (hist_bin),
        .hist_count    (hist_count),
        .pix_cnt       (pix_cnt),
        .hist_done     (hist_done)
`ifdef LBP_HIST_ADDR_CHECK_EN
        ,
        .addr_err      (addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  bin;
        logic [13:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   exp_bins[256];
    int   exp_pix;
    int   n_checks;
    int   n_errors;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 256; b++) exp_bins[b] = 0;
        exp_pix = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        lbp_valid     = 1'b0;
        lbp_data      = 8'd0;
        lbp_addr      = 14'd0;
        finish        = 1'b0;
        hist_rd_ready = 1'b0;
        tick();
        check_eq("rst_ready", 32'(hist_ready), 0);
        check_eq("rst_valid", 32'(hist_valid), 0);
        check_eq("rst_bin", 32'(hist_bin), 0);
        check_eq("rst_count", 32'(hist_count), 0);
        check_eq("rst_pix", 32'(pix_cnt), 0);
        check_eq("rst_done", 32'(hist_done), 0);
        reset = 1'b0;
        clear_model();
    endtask

    // Count clock edges from reset release until hist_ready rises.
    task automatic wait_accum();
        int n;
        n = 0;
        while (!hist_ready && n < 300) begin
            tick();
            n++;
        end
        check_eq("clear_len", 32'(n), 256);
        check_eq("accum_pix0", 32'(pix_cnt), 0);
    endtask

    task automatic send(input logic [7:0] code, input bit with_finish);
        lbp_valid = 1'b1;
        lbp_data  = code;
        lbp_addr  = {7'd10, 7'd10};
        finish    = with_finish;
        tick();
        if (exp_bins[code] < MAXC) exp_bins[code]++;
        if (exp_pix < MAXC) exp_pix++;
    endtask

    // Leave ACCUM (if finish has not been seen yet) and load the scoreboard.
    task automatic end_accum();
        exp_t e;
        lbp_valid = 1'b0;
        if (!finish) begin
            finish = 1'b1;
            tick();
        end
        for (int b = 0; b < 256; b++) begin
            e.bin = 8'(b);
            e.cnt = 14'(exp_bins[b]);
            exp_q.push_back(e);
        end
        check_eq("dump_entry_valid", 32'(hist_valid), 1);
        check_eq("dump_entry_ready", 32'(hist_ready), 0);
        check_eq("dump_pix", 32'(pix_cnt), 32'(exp_pix));
    endtask

    task automatic run_dump(input bit stall);
        bit          pat[4];
        int          seq[5];
        int          cyc;
        bit          rdy;
        bit          held;
        logic [7:0]  hold_bin;
        logic [13:0] hold_cnt;
        exp_t        e;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        seq  = '{0, 1, 1, 1, 2};
        cyc  = 0;
        held = 1'b0;
        hold_bin = 8'd0;
        hold_cnt = 14'd0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            rdy = (stall && cyc < 4) ? pat[cyc] : 1'b1;
            hist_rd_ready = rdy;
            check_eq("dump_valid", 32'(hist_valid), 1);
            if (stall && cyc < 5) check_eq("stall_seq", 32'(hist_bin), 32'(seq[cyc]));
            if (held) begin
                check_eq("stall_bin_hold", 32'(hist_bin), 32'(hold_bin));
                check_eq("stall_cnt_hold", 32'(hist_count), 32'(hold_cnt));
            end
            held     = !rdy;
            hold_bin = hist_bin;
            hold_cnt = hist_count;
            if (rdy) begin
                e = exp_q.pop_front();
                check_eq("dump_bin", 32'(hist_bin), 32'(e.bin));
                check_eq("dump_count", 32'(hist_count), 32'(e.cnt));
            end
            tick();
            cyc++;
        end
        hist_rd_ready = 1'b0;
        if (exp_q.size() != 0) check_eq("dump_timeout", 32'(exp_q.size()), 0);
        check_eq("done_flag", 32'(hist_done), 1);
        check_eq("done_valid", 32'(hist_valid), 0);
        check_eq("done_ready", 32'(hist_ready), 0);
        check_eq("done_pix", 32'(pix_cnt), 32'(exp_pix));
        lbp_valid = 1'b1;
        hist_rd_ready = 1'b1;
        tick();
        tick();
        lbp_valid = 1'b0;
        hist_rd_ready = 1'b0;
        check_eq("done_sticky", 32'(hist_done), 1);
        check_eq("done_bin0", 32'(hist_bin), 0);
        check_eq("done_pix_frozen", 32'(pix_cnt), 32'(exp_pix));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;

        // lbp_valid held through CLEAR: nothing counted, all bins dump as 0.
        do_reset();
        lbp_valid = 1'b1;
        lbp_data  = 8'h11;
        wait_accum();
        lbp_valid = 1'b0;
        end_accum();
        run_dump(1'b0);

        // Back-to-back same code, finish together with the last result, stalled dump.
        do_reset();
        wait_accum();
        send(8'd3, 1'b0);
        send(8'd3, 1'b0);
        send(8'd7, 1'b1);
        end_accum();
        run_dump(1'b1);

        // finish already high when ACCUM is entered: one ACCUM cycle then DUMP.
        do_reset();
        finish = 1'b1;
        wait_accum();
        check_eq("early_fin_valid", 32'(hist_valid), 0);
        tick();
        end_accum();
        run_dump(1'b0);

        // Full 128x128 interior run, all code 0xFF.
        do_reset();
        wait_accum();
        for (int i = 0; i < 15876; i++) send(8'hFF, 1'b0);
        end_accum();
        run_dump(1'b0);

        // Saturation of bin and pixel counter.
        do_reset();
        wait_accum();
        for (int i = 0; i < 16390; i++) send(8'd5, 1'b0);
        end_accum();
        run_dump(1'b0);

        // Reset in the middle of DUMP, then a fresh single-code run.
        do_reset();
        wait_accum();
        send(8'd100, 1'b0);
        send(8'd100, 1'b0);
        send(8'd100, 1'b0);
        end_accum();
        exp_q.delete();
        hist_rd_ready = 1'b1;
        n = 0;
        while (hist_bin != 8'd100 && n < 300) begin
            tick();
            n++;
        end
        check_eq("mid_reach_bin", 32'(hist_bin), 100);
        check_eq("mid_bin_count", 32'(hist_count), 3);
        reset = 1'b1;
        hist_rd_ready = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_valid", 32'(hist_valid), 0);
        check_eq("mid_rst_bin", 32'(hist_bin), 0);
        check_eq("mid_rst_count", 32'(hist_count), 0);
        check_eq("mid_rst_ready", 32'(hist_ready), 0);
        check_eq("mid_rst_pix", 32'(pix_cnt), 0);
        clear_model();
        finish = 1'b0;
        wait_accum();
        send(8'd9, 1'b1);
        end_accum();
        run_dump(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
